// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for pipe_stage_reg.
// The master modport belongs to the side that drives the upstream payload and the downstream ready.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 5
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_a_i;
    logic [DATA_W-1:0] data_b_i;
    logic [ADDR_W-1:0] rd_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_a_o;
    logic [DATA_W-1:0] data_b_o;
    logic [ADDR_W-1:0] rd_o;

    modport master (
        output flush_i, in_valid_i, ctrl_i, data_a_i, data_b_i, rd_i, out_ready_i,
        input  in_ready_o, out_valid_o, ctrl_o, data_a_o, data_b_o, rd_o
    );

    modport slave (
        input  flush_i, in_valid_i, ctrl_i, data_a_i, data_b_i, rd_i, out_ready_i,
        output in_ready_o, out_valid_o, ctrl_o, data_a_o, data_b_o, rd_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register built as a 2-entry skid buffer with flush and bubble insertion.
// Define PIPE_STALL_CNT_EN to add the saturating stall cycle counter on stall_cnt_o.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_stage_reg_if.slave  bus
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o
`endif
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data_a;
        logic [DATA_W-1:0] data_b;
        logic [ADDR_W-1:0] rd;
    } entry_t;

    logic   main_valid;
    logic   main_valid_next;
    logic   skid_valid;
    logic   skid_valid_next;
    entry_t main_q;
    entry_t main_next;
    entry_t skid_q;
    entry_t skid_next;
    entry_t in_entry;
    logic   in_xfer;
    logic   out_xfer;

    assign in_entry = {bus.ctrl_i, bus.data_a_i, bus.data_b_i, bus.rd_i};
    assign in_xfer  = bus.in_valid_i & ~skid_valid & ~bus.flush_i;
    assign out_xfer = main_valid & bus.out_ready_i;

    // Skid only fills while main is held, so it always drains into main before any newer input.
    always_comb begin
        main_valid_next = main_valid;
        skid_valid_next = skid_valid;
        main_next       = main_q;
        skid_next       = skid_q;
        if (bus.flush_i) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid || out_xfer) begin
            if (skid_valid) begin
                main_next       = skid_q;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end else if (in_xfer) begin
                main_next       = in_entry;
                main_valid_next = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (in_xfer) begin
            skid_next       = in_entry;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_valid <= main_valid_next;
            skid_valid <= skid_valid_next;
            main_q     <= main_next;
            skid_q     <= skid_next;
        end
    end

    // Ready comes straight from the skid register, so out_ready_i never reaches in_ready_o.
    assign bus.in_ready_o  = ~skid_valid;
    assign bus.out_valid_o = main_valid;
    assign bus.ctrl_o      = main_valid ? main_q.ctrl : '0;
    assign bus.data_a_o    = main_q.data_a;
    assign bus.data_b_o    = main_q.data_b;
    assign bus.rd_o        = main_q.rd;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Counts held-output cycles; flush leaves it alone, only reset clears it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (main_valid && !bus.out_ready_i && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    // CNT_W only sizes the optional counter; this empty guard keeps it referenced when compiled out.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a table of per-cycle vectors plus hand-written
// sequences for asynchronous reset and (with PIPE_STALL_CNT_EN) counter saturation.
module tb_pipe_stage_reg;

    logic clk;
    logic rst_n;
`ifdef PIPE_STALL_CNT_EN
    logic [3:0] stall_cnt;
`endif

    int check_count;
    int pass_count;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(4), .ADDR_W(5)) bus ();

    pipe_stage_reg #(
        .DATA_W(32),
        .CTRL_W(4),
        .ADDR_W(5),
        .CNT_W (4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt_o(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        flush;
        logic        in_valid;
        logic [3:0]  ctrl;
        logic [31:0] data_a;
        logic [4:0]  rd;
        logic        out_ready;
        logic        exp_valid;
        logic        exp_ready;
        logic [3:0]  exp_ctrl;
        logic [31:0] exp_a;
        logic [4:0]  exp_rd;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic flush, input logic in_valid,
                                input logic [3:0] ctrl, input logic [31:0] data_a,
                                input logic [4:0] rd, input logic out_ready,
                                input logic exp_valid, input logic exp_ready,
                                input logic [3:0] exp_ctrl, input logic [31:0] exp_a,
                                input logic [4:0] exp_rd, input logic [15:0] exp_cnt);
        vec_t v;
        v.name = name;       v.flush = flush;         v.in_valid = in_valid;
        v.ctrl = ctrl;       v.data_a = data_a;       v.rd = rd;
        v.out_ready = out_ready;
        v.exp_valid = exp_valid; v.exp_ready = exp_ready; v.exp_ctrl = exp_ctrl;
        v.exp_a = exp_a;     v.exp_rd = exp_rd;       v.exp_cnt = exp_cnt;
        return v;
    endfunction

    // data_b always carries the complement of data_a so both payload lanes are exercised.
    task automatic applyStimulus(input logic flush, input logic in_valid, input logic [3:0] ctrl,
                                 input logic [31:0] data_a, input logic [4:0] rd,
                                 input logic out_ready);
        bus.flush_i     = flush;
        bus.in_valid_i  = in_valid;
        bus.ctrl_i      = ctrl;
        bus.data_a_i    = data_a;
        bus.data_b_i    = ~data_a;
        bus.rd_i        = rd;
        bus.out_ready_i = out_ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        else
            pass_count++;
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".out_valid"}, 32'(bus.out_valid_o), 32'(v.exp_valid));
        checkOutput({v.name, ".in_ready"},  32'(bus.in_ready_o),  32'(v.exp_ready));
        checkOutput({v.name, ".ctrl"},      32'(bus.ctrl_o),      32'(v.exp_ctrl));
        checkOutput({v.name, ".data_a"},    bus.data_a_o,         v.exp_a);
        checkOutput({v.name, ".data_b"},    bus.data_b_o,         ~v.exp_a);
        checkOutput({v.name, ".rd"},        32'(bus.rd_o),        32'(v.exp_rd));
`ifdef PIPE_STALL_CNT_EN
        checkOutput({v.name, ".stall_cnt"}, 32'(stall_cnt),       32'(v.exp_cnt));
`endif
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;

        // Single payload, streaming, stall with skid fill, flush, and flush during output transfer.
        vecs.push_back(mk("r32_load",  0,1,4'hB,32'h12345678, 5,1, 1,1,4'hB,32'h12345678, 5,0));
        vecs.push_back(mk("r32_drain", 0,0,4'h0,32'h0,        0,1, 0,1,4'h0,32'h12345678, 5,0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk($sformatf("r33_s%0d", i), 0,1,4'(i),32'(i),5'(i),1,
                              1,1,4'(i),32'(i),5'(i),0));
        vecs.push_back(mk("r33_drain", 0,0,4'h0,32'h0,        0,1, 0,1,4'h0,32'h8,        8,0));
        vecs.push_back(mk("r34_a",     0,1,4'h3,32'hA0A0A0A0,10,0, 1,1,4'h3,32'hA0A0A0A0,10,0));
        vecs.push_back(mk("r34_b",     0,1,4'h3,32'hB0B0B0B0,11,0, 1,0,4'h3,32'hA0A0A0A0,10,1));
        vecs.push_back(mk("r34_c1",    0,1,4'h3,32'hC0C0C0C0,12,0, 1,0,4'h3,32'hA0A0A0A0,10,2));
        vecs.push_back(mk("r34_c2",    0,1,4'h3,32'hC0C0C0C0,12,0, 1,0,4'h3,32'hA0A0A0A0,10,3));
        vecs.push_back(mk("r34_rel_a", 0,1,4'h3,32'hC0C0C0C0,12,1, 1,1,4'h3,32'hB0B0B0B0,11,3));
        vecs.push_back(mk("r34_rel_b", 0,1,4'h3,32'hC0C0C0C0,12,1, 1,1,4'h3,32'hC0C0C0C0,12,3));
        vecs.push_back(mk("r34_drain", 0,0,4'h0,32'h0,        0,1, 0,1,4'h0,32'hC0C0C0C0,12,3));
        vecs.push_back(mk("r35_d",     0,1,4'h5,32'hD0D0D0D0,13,0, 1,1,4'h5,32'hD0D0D0D0,13,3));
        vecs.push_back(mk("r35_e",     0,1,4'h6,32'hE0E0E0E0,14,0, 1,0,4'h5,32'hD0D0D0D0,13,4));
        vecs.push_back(mk("r35_flush", 1,1,4'h7,32'hF0F0F0F0,15,0, 0,1,4'h0,32'hD0D0D0D0,13,5));
        vecs.push_back(mk("r35_after", 0,0,4'h0,32'h0,        0,1, 0,1,4'h0,32'hD0D0D0D0,13,5));
        vecs.push_back(mk("r35_g",     0,1,4'h9,32'h13572468,17,1, 1,1,4'h9,32'h13572468,17,5));
        vecs.push_back(mk("r35_gdrain",0,0,4'h0,32'h0,        0,1, 0,1,4'h0,32'h13572468,17,5));
        vecs.push_back(mk("r25_h",     0,1,4'hC,32'hCAFEF00D,20,1, 1,1,4'hC,32'hCAFEF00D,20,5));
        vecs.push_back(mk("r25_flush", 1,1,4'hD,32'hDEADBEEF,21,1, 0,1,4'h0,32'hCAFEF00D,20,5));
        vecs.push_back(mk("r25_after", 0,0,4'h0,32'h0,        0,1, 0,1,4'h0,32'hCAFEF00D,20,5));

        rst_n = 1'b0;
        applyStimulus(0, 0, 4'h0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset.out_valid", 32'(bus.out_valid_o), 32'd0);
        checkOutput("reset.in_ready",  32'(bus.in_ready_o),  32'd1);
        checkOutput("reset.ctrl",      32'(bus.ctrl_o),      32'd0);
        checkOutput("reset.data_a",    bus.data_a_o,         32'd0);
        checkOutput("reset.rd",        32'(bus.rd_o),        32'd0);
`ifdef PIPE_STALL_CNT_EN
        checkOutput("reset.stall_cnt", 32'(stall_cnt),       32'd0);
`endif
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].flush, vecs[i].in_valid, vecs[i].ctrl, vecs[i].data_a,
                          vecs[i].rd, vecs[i].out_ready);
            @(negedge clk);
            checkVector(vecs[i]);
        end

        // Asynchronous reset in the middle of a stall, then a transfer on the first edge after release.
        applyStimulus(0, 1, 4'hA, 32'h0BAD0001, 5'd7, 1'b0);
        @(negedge clk);
        checkOutput("r36_load.out_valid", 32'(bus.out_valid_o), 32'd1);
        applyStimulus(0, 0, 4'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        checkOutput("r36_stall.data_a", bus.data_a_o, 32'h0BAD0001);
        rst_n = 1'b0;
        #1;
        checkOutput("r36_async.out_valid", 32'(bus.out_valid_o), 32'd0);
        checkOutput("r36_async.ctrl",      32'(bus.ctrl_o),      32'd0);
        checkOutput("r36_async.in_ready",  32'(bus.in_ready_o),  32'd1);
        checkOutput("r36_async.data_a",    bus.data_a_o,         32'd0);
`ifdef PIPE_STALL_CNT_EN
        checkOutput("r36_async.stall_cnt", 32'(stall_cnt),       32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 4'h2, 32'h2468ACE0, 5'd9, 1'b1);
        @(negedge clk);
        checkOutput("r28_first.out_valid", 32'(bus.out_valid_o), 32'd1);
        checkOutput("r28_first.ctrl",      32'(bus.ctrl_o),      32'd2);
        checkOutput("r28_first.data_a",    bus.data_a_o,         32'h2468ACE0);
        applyStimulus(0, 0, 4'h0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        checkOutput("r28_drain.out_valid", 32'(bus.out_valid_o), 32'd0);

`ifdef PIPE_STALL_CNT_EN
        // A long stall must pin a 4-bit counter at 15 rather than wrap.
        applyStimulus(0, 1, 4'h1, 32'h00000055, 5'd1, 1'b0);
        @(negedge clk);
        applyStimulus(0, 0, 4'h0, 32'h0, 5'd0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 14) checkOutput("r37_k14.stall_cnt", 32'(stall_cnt), 32'd14);
        end
        checkOutput("r37_sat.stall_cnt", 32'(stall_cnt),       32'd15);
        checkOutput("r37_sat.out_valid", 32'(bus.out_valid_o), 32'd1);
        checkOutput("r37_sat.data_a",    bus.data_a_o,         32'h00000055);
        applyStimulus(0, 0, 4'h0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
